// File: rtl/valid_pair_join.sv
// valid_pair_join
// Joins two valid/ready streams. Holds one beat from A and one beat from B,
// then moves the pair into a registered output slot, so out_valid is a clean
// flop output. The hold stage and the output slot both drain and refill in
// the same cycle, which sustains one joined beat per clock.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   a_valid/a_ready/a_data stream A input handshake and payload
//   b_valid/b_ready/b_data stream B input handshake and payload
//   out_valid/out_ready    joined output handshake
//   out_a, out_b           payloads of the joined beat
//   pair_count             joined beats taken downstream, wraps mod 2^CNT_W
//
// Hold-stage states ({a_full, b_full})
//   state  | meaning
//   EMPTY  | no beat held
//   B_ONLY | B beat held, waiting for A
//   A_ONLY | A beat held, waiting for B
//   BOTH   | pair held, waiting for a free output slot
module valid_pair_join #(
   parameter int A_W   = 8,
   parameter int B_W   = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [A_W-1:0]   a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [B_W-1:0]   b_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [A_W-1:0]   out_a,
   output logic [B_W-1:0]   out_b,
   output logic [CNT_W-1:0] pair_count
);

   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      B_ONLY = 2'b01,
      A_ONLY = 2'b10,
      BOTH   = 2'b11
   } hold_state_t;

   hold_state_t     state;
   logic [A_W-1:0]  a_hold;
   logic [B_W-1:0]  b_hold;

   logic a_full;
   logic b_full;
   logic out_slot_free;
   logic move;
   logic a_acc;
   logic b_acc;
   logic a_full_nxt;
   logic b_full_nxt;

   assign a_full = state[1];
   assign b_full = state[0];

   // Readies depend only on registered state and out_ready, never on the
   // input valids, so no combinational path runs from a_valid/b_valid.
   assign out_slot_free = !out_valid || out_ready;
   assign move          = a_full && b_full && out_slot_free;
   assign a_ready       = !a_full || move;
   assign b_ready       = !b_full || move;
   assign a_acc         = a_valid && a_ready;
   assign b_acc         = b_valid && b_ready;

   // A same-cycle accept wins over the drain caused by move (refill).
   always_comb begin
      a_full_nxt = a_full;
      b_full_nxt = b_full;
      if (a_acc) begin
         a_full_nxt = 1'b1;
      end else if (move) begin
         a_full_nxt = 1'b0;
      end
      if (b_acc) begin
         b_full_nxt = 1'b1;
      end else if (move) begin
         b_full_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         a_hold     <= '0;
         b_hold     <= '0;
         out_valid  <= 1'b0;
         out_a      <= '0;
         out_b      <= '0;
         pair_count <= '0;
      end else begin
         state <= hold_state_t'({a_full_nxt, b_full_nxt});
         if (a_acc) begin
            a_hold <= a_data;
         end
         if (b_acc) begin
            b_hold <= b_data;
         end
         if (move) begin
            out_valid <= 1'b1;
            out_a     <= a_hold;
            out_b     <= b_hold;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready) begin
            pair_count <= pair_count + 1'b1;
         end
      end
   end

endmodule
